// File: rtl/div_unit_pkg.sv
// Shared constants for the execute-stage divider: state codes, handshake
// levels, bus widths and a small two's-complement helper.
package div_unit_pkg;

    // Bus widths
    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    localparam logic [RegBus-1:0] ZeroWord  = 32'h0000_0000;
    localparam logic              RstEnable = 1'b1;

    // Divider state codes (2-bit legacy encoding)
    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

    // Request / completion levels
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // Two's-complement negation of a register-width word
    function automatic logic [RegBus-1:0] twos_neg(input logic [RegBus-1:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the divider.
//
// Handshake: the execute stage raises start_i with operands valid and keeps
// start_i and the operands stable until it sees ready_o=1; ready_o then stays
// high with result_o stable for as long as start_i is held, and the divider
// returns to idle on the first edge after start_i drops. annul_i cancels any
// operation in flight and returns the divider to idle with outputs cleared.
interface div_unit_if;
    import div_unit_pkg::*;

    logic                    signed_div_i;
    logic [RegBus-1:0]       opdata1_i;
    logic [RegBus-1:0]       opdata2_i;
    logic                    start_i;
    logic                    annul_i;
    logic [DoubleRegBus-1:0] result_o;
    logic                    ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );

endinterface

// File: rtl/div_unit.sv
// Multi-cycle 32-bit signed/unsigned divider (radix-2 restoring,
// one quotient bit per cycle). result_o = {remainder, quotient}.
// Signed operands are reduced to magnitudes up front; signs are
// reapplied to the final quotient/remainder. dbg_state exposes the FSM.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    div_unit_if.slave   bus,
    output logic [1:0]  dbg_state
);

    logic [1:0]              state;
    logic [5:0]              cnt;
    logic [64:0]             dividend;
    logic [RegBus-1:0]       divisor;
    logic                    signed_lat;
    logic                    op1_neg;
    logic                    op2_neg;
    logic [DoubleRegBus-1:0] result_q;
    logic                    ready_q;

    logic [32:0]             trial;
    logic [RegBus-1:0]       quot_fin;
    logic [RegBus-1:0]       rem_fin;
    logic                    start_op1_neg;
    logic                    start_op2_neg;

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
    assign dbg_state    = state;

    // Trial subtraction and sign-corrected final results
    always_comb begin
        trial    = {1'b0, dividend[63:32]} - {1'b0, divisor};
        quot_fin = (signed_lat && (op1_neg ^ op2_neg)) ? twos_neg(dividend[31:0])
                                                       : dividend[31:0];
        rem_fin  = (signed_lat && op1_neg) ? twos_neg(dividend[64:33])
                                           : dividend[64:33];
        start_op1_neg = bus.signed_div_i & bus.opdata1_i[31];
        start_op2_neg = bus.signed_div_i & bus.opdata2_i[31];
    end

    // Divider FSM: accept, iterate, deliver, hold until start drops
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state      <= DivFree;
            cnt        <= 6'd0;
            ready_q    <= DivResultNotReady;
            result_q   <= '0;
            dividend   <= '0;
            divisor    <= ZeroWord;
            signed_lat <= 1'b0;
            op1_neg    <= 1'b0;
            op2_neg    <= 1'b0;
        end else begin
            case (state)
                DivFree: begin
                    ready_q  <= DivResultNotReady;
                    result_q <= '0;
                    if (bus.start_i == DivStart && !bus.annul_i) begin
                        if (bus.opdata2_i == ZeroWord) begin
                            state <= DivByZero;
                        end else begin
                            state      <= DivOn;
                            cnt        <= 6'd0;
                            signed_lat <= bus.signed_div_i;
                            op1_neg    <= bus.opdata1_i[31];
                            op2_neg    <= bus.opdata2_i[31];
                            dividend   <= {32'b0,
                                           start_op1_neg ? twos_neg(bus.opdata1_i)
                                                         : bus.opdata1_i,
                                           1'b0};
                            divisor    <= start_op2_neg ? twos_neg(bus.opdata2_i)
                                                        : bus.opdata2_i;
                        end
                    end
                end
                DivByZero: begin
                    if (bus.annul_i) begin
                        state    <= DivFree;
                        ready_q  <= DivResultNotReady;
                        result_q <= '0;
                        cnt      <= 6'd0;
                    end else begin
                        state    <= DivEnd;
                        ready_q  <= DivResultReady;
                        result_q <= '0;
                    end
                end
                DivOn: begin
                    if (bus.annul_i) begin
                        state    <= DivFree;
                        ready_q  <= DivResultNotReady;
                        result_q <= '0;
                        cnt      <= 6'd0;
                    end else if (cnt != 6'(WIDTH)) begin
                        // Borrow set: partial remainder smaller than divisor
                        if (trial[32]) begin
                            dividend <= {dividend[63:0], 1'b0};
                        end else begin
                            dividend <= {trial[31:0], dividend[31:0], 1'b1};
                        end
                        cnt <= cnt + 6'd1;
                    end else begin
                        state    <= DivEnd;
                        ready_q  <= DivResultReady;
                        result_q <= {rem_fin, quot_fin};
                        cnt      <= 6'd0;
                    end
                end
                DivEnd: begin
                    if (bus.annul_i || bus.start_i == DivStop) begin
                        state    <= DivFree;
                        ready_q  <= DivResultNotReady;
                        result_q <= '0;
                        cnt      <= 6'd0;
                    end
                end
                default: state <= DivFree;
            endcase
        end
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit signed/unsigned divider serving the execute stage for DIV/DIVU.
- Execute stage drives operands plus start and stalls the pipeline until ready_o.
- Execute stage then writes result_o[63:32] (remainder) to HI and result_o[31:0] (quotient) to LO.
- Radix-2 restoring shift-subtract, one quotient bit per cycle; abortable via annul_i (pipeline flush).

Parameters:
- WIDTH, 32, operand width. Only 32 is supported; it fixes the counter range 0..32.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- opdata1_i  in  32  dividend.
- opdata2_i  in  32  divisor.
- start_i  in  1  DivStart(1)/DivStop(0); held high by requester until ready_o seen.
- annul_i  in  1  abort current operation (exception/flush).
- result_o  out  64  {remainder, quotient}, registered.
- ready_o  out  1  DivResultReady(1)/DivResultNotReady(0), registered.

Behaviour:
- Reset (rst=1 at edge): state=FREE, cnt=0, ready_o=0, result_o=0; overrides every other input, including mid-operation.
- States: FREE, BYZERO, ON, END (2-bit encoding).
- FREE, start_i=1, annul_i=0, opdata2_i=0: go to BYZERO.
- FREE, start_i=1, annul_i=0, opdata2_i!=0: go to ON with cnt=0.
  - If signed and an operand is negative, latch its two's-complement magnitude; otherwise latch raw.
  - Also latch signed_div_i and both operand sign bits.
  - Working register dividend[64:0] = {32'b0, |op1|, 1'b0}.
- FREE, any other input combination: stay; ready_o=0, result_o=0.
- BYZERO: next edge result_o=0, ready_o=1, state=END.
- ON, annul_i=1: state=FREE, ready_o=0, result_o=0, cnt=0.
- ON, cnt<32, one iteration per edge:
  - t = {1'b0, dividend[63:32]} - {1'b0, |divisor|}.
  - If t[32]=1: dividend <= {dividend[63:0], 1'b0}.
  - Else: dividend <= {t[31:0], dividend[31:0], 1'b1}.
  - cnt <= cnt+1.
- ON, cnt==32:
  - quotient = dividend[31:0]; negated if signed and sign(op1)^sign(op2).
  - remainder = dividend[64:33]; negated if signed and op1 negative.
  - result_o = {remainder, quotient}, ready_o=1, state=END, cnt=0.
- Operand magnitude 0x80000000 is handled as unsigned 2^31. -2^31 / -1 yields quotient 0x80000000 (wraps), remainder 0; no trap.
- END, start_i=1: hold ready_o=1 and result_o stable.
- END, start_i=0: state=FREE, ready_o=0, result_o=0 at next edge.
- annul_i in BYZERO or END: behaves as for ON (to FREE, outputs cleared).
- Latency, counting the edge that samples start in FREE as edge 1: ready_o high after edge 34; divide-by-zero ready after edge 2.
- Operands must be held stable by the requester, but are only sampled in FREE; changes during ON are ignored.

Decomposition:
- Shared defines header holds:
  - Div state codes: DivFree, DivByZero, DivOn, DivEnd.
  - DivStart/DivStop and DivResultReady/DivResultNotReady.
  - DoubleRegBus, RegBus, ZeroWord, RstEnable.
- No sub-module: the iteration subtractor is inline; a separate module would only be a thin adder wrapper.

Test Plan:
- Unsigned 100/7, start held: ready_o after edge 34, result_o=0x00000002_0000000E. Drop start: ready_o=0, result_o=0 next edge.
- Signed -7/2 (0xFFFFFFF9/0x00000002): result_o=0xFFFFFFFF_FFFFFFFD. Signed 7/-2: result_o=0x00000001_FFFFFFFD.
- Signed 0x80000000/0xFFFFFFFF: result_o=0x00000000_80000000. Unsigned 0xFFFFFFFF/0x00000001: result_o=0x00000000_FFFFFFFF.
- Divide by zero (any dividend): ready_o=1 after edge 2 with result_o=0. Stays high while start held; clears after start drops.
- annul_i pulsed at edge 10 of an operation: next state FREE, ready_o=0. Immediate new unsigned 9/3 completes with result_o=0x00000000_00000003.
- rst asserted at edge 20 mid-operation: all outputs 0, state FREE. Fresh start then completes normally with correct result.
